// File: rtl/frame_wr_cmd_gen.sv
// frame_wr_cmd_gen
// Packs a 16-bit pixel stream into MEM_DQ_WIDTH*8-bit beats and buffers them
// in a first-word-fall-through FIFO. Whenever a full burst is buffered, it
// issues one write command to a DDR write controller and serves that burst's
// beats. Command addresses walk through the frame buffer and wrap back to
// BASE_ADDR at every frame boundary.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   frame_start              one-cycle pulse marking a new frame
//   pix_valid, pix_data      pixel input (pix_data qualified by pix_valid)
//   wr_cmd_en                one-cycle write command request (asserted in CMD)
//   wr_cmd_addr, wr_cmd_len  command start address / length in beats
//   wr_cmd_ready             controller can accept a command (checked in IDLE)
//   wr_cmd_done              one-cycle pulse when the controller completes a command
//   wr_data_re               controller beat read strobe (one beat per cycle)
//   wr_ctrl_data             head beat of the buffer (combinational)
//   fifo_level               number of buffered beats
//   overflow, underflow      sticky error flags, cleared only by rst
//   frame_done               one-cycle pulse when the last command of a frame completes
//   dbg_state                current FSM state
//
// Handshake semantics: a command is offered only from IDLE while wr_cmd_ready
// is high, and is then asserted for exactly one cycle on wr_cmd_en; the
// controller does not back-pressure that cycle. Each cycle with wr_data_re
// high consumes the beat currently on wr_ctrl_data; a strobe against an empty
// buffer consumes nothing and raises underflow.
module frame_wr_cmd_gen #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int BURST_BEATS     = 16,
  parameter int FIFO_DEPTH      = 64,
  parameter int FRAME_BEATS     = 129600,
  parameter int BASE_ADDR       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             pix_valid,
  input  logic [15:0]                      pix_data,
  output logic                             wr_cmd_en,
  output logic [CTRL_ADDR_WIDTH-1:0]       wr_cmd_addr,
  output logic [31:0]                      wr_cmd_len,
  input  logic                             wr_cmd_ready,
  input  logic                             wr_cmd_done,
  input  logic                             wr_data_re,
  output logic [MEM_DQ_WIDTH*8-1:0]        wr_ctrl_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             frame_done,
  output logic [1:0]                       dbg_state
);

  localparam int BEAT_W       = MEM_DQ_WIDTH * 8;
  localparam int PIX_PER_BEAT = BEAT_W / 16;
  localparam int PC_W         = $clog2(PIX_PER_BEAT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = AW + 1;
  localparam int CNT_W        = $clog2(BURST_BEATS);

  localparam logic [CTRL_ADDR_WIDTH-1:0] BASE      = CTRL_ADDR_WIDTH'(BASE_ADDR);
  // Address unit is one MEM_DQ_WIDTH word, and a beat holds 8 of them.
  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_STEP = CTRL_ADDR_WIDTH'(BURST_BEATS * 8);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CMD       = 2'd1;
  localparam logic [1:0] DATA      = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  // ---------------------------------------------------------------------------
  // Pixel packing
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]    pack_cnt;
  logic [PC_W-1:0]    pack_idx;
  logic [BEAT_W-17:0] pack_data;   // pixels 0..N-2; the last one goes straight into the beat
  logic               push_v;
  logic [BEAT_W-1:0]  push_beat;

  // frame_start restarts packing in the same cycle, so a coincident pixel
  // lands in slot 0 and any partial beat is abandoned.
  always_comb begin
    pack_idx = frame_start ? '0 : pack_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_cnt  <= '0;
      pack_data <= '0;
      push_v    <= 1'b0;
      push_beat <= '0;
    end else begin
      push_v <= 1'b0;
      if (pix_valid) begin
        if (pack_idx == PC_W'(PIX_PER_BEAT - 1)) begin
          push_v    <= 1'b1;
          push_beat <= {pix_data, pack_data};
        end else begin
          pack_data[int'(pack_idx) * 16 +: 16] <= pix_data;
        end
        pack_cnt <= pack_idx + 1'b1;
      end else if (frame_start) begin
        pack_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat buffer (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [BEAT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [BEAT_W-1:0] hold_data;    // last beat presented; shown while empty
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_eff;
  logic              push_eff;
  logic              flush;

  logic [1:0]                 state;
  logic [CTRL_ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]                beat_cnt;
  logic [CNT_W-1:0]           pop_cnt;
  logic                       done_lat;
  logic                       fs_pend;
  logic                       complete;

  always_comb begin
    fifo_level = wr_ptr - rd_ptr;
    fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    fifo_empty = (fifo_level == '0);
    pop_eff    = wr_data_re && !fifo_empty;
    // A pop in the same cycle frees the slot a full-buffer push needs.
    push_eff   = push_v && (!fifo_full || pop_eff) && !flush;
    complete   = (state == WAIT_DONE) && (wr_cmd_done || done_lat);
    // Flush immediately from IDLE; otherwise only once the in-flight command
    // completes, so its beats are still served.
    flush      = ((state == IDLE) && frame_start) ||
                 (complete && (fs_pend || frame_start));
    wr_ctrl_data = fifo_empty ? hold_data : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr[AW-1:0]] <= push_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hold_data <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_v && fifo_full && !pop_eff && !flush) begin
        overflow <= 1'b1;
      end
      if (wr_data_re && fifo_empty) begin
        underflow <= 1'b1;
      end
      if (pop_eff) begin
        hold_data <= mem[rd_ptr[AW-1:0]];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_eff) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop_eff) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= BASE;
      beat_cnt   <= '0;
      pop_cnt    <= '0;
      done_lat   <= 1'b0;
      fs_pend    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            cur_addr <= BASE;
            beat_cnt <= '0;
          end else if ((fifo_level >= LVL_W'(BURST_BEATS)) && wr_cmd_ready) begin
            state <= CMD;
          end
        end
        CMD: begin
          state    <= DATA;
          pop_cnt  <= '0;
          done_lat <= 1'b0;
          if (frame_start) begin
            fs_pend <= 1'b1;
          end
        end
        DATA: begin
          if (frame_start) begin
            fs_pend <= 1'b1;
          end
          // A done pulse arriving with the final pop counts as completion.
          if (wr_cmd_done) begin
            done_lat <= 1'b1;
          end
          if (pop_eff) begin
            if (pop_cnt == CNT_W'(BURST_BEATS - 1)) begin
              state <= WAIT_DONE;
            end else begin
              pop_cnt <= pop_cnt + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (complete) begin
            state    <= IDLE;
            done_lat <= 1'b0;
            fs_pend  <= 1'b0;
            if (beat_cnt + 32'(BURST_BEATS) == 32'(FRAME_BEATS)) begin
              beat_cnt   <= '0;
              cur_addr   <= BASE;
              frame_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 32'(BURST_BEATS);
              cur_addr <= cur_addr + ADDR_STEP;
            end
            // A pending new frame overrides the normal advance.
            if (fs_pend || frame_start) begin
              beat_cnt <= '0;
              cur_addr <= BASE;
            end
          end else if (frame_start) begin
            fs_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_cmd_en   = (state == CMD);
    wr_cmd_addr = cur_addr;
    wr_cmd_len  = (state == CMD) ? 32'(BURST_BEATS) : 32'd0;
    dbg_state   = state;
  end

endmodule

// File: doc/frame_wr_cmd_gen.md
FRAME_WR_CMD_GEN -- requirements
Module: frame_wr_cmd_gen

Interface
REQ-001 Parameter CTRL_ADDR_WIDTH, default 28, SHALL be the DDR controller address width.
REQ-002 Parameter MEM_DQ_WIDTH, default 16, SHALL be the DDR DQ width; data beat width is MEM_DQ_WIDTH*8 (128).
REQ-003 Parameter BURST_BEATS, default 16, SHALL be the number of beats per write command.
REQ-004 Parameter FIFO_DEPTH, default 64, SHALL be the beat buffer depth in beats (power of 2, at least 2*BURST_BEATS).
REQ-005 Parameter FRAME_BEATS, default 129600, SHALL be the number of beats per frame (integer multiple of BURST_BEATS).
REQ-006 Parameter BASE_ADDR, default 0, SHALL be the frame start address.
REQ-007 clk  input  1  SHALL be the single clock; all logic is synchronous to its rising edge.
REQ-008 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-009 frame_start  input  1  SHALL be a one-cycle pulse marking a new frame.
REQ-010 pix_valid  input  1  SHALL qualify pix_data.
REQ-011 pix_data  input  16  SHALL be one pixel.
REQ-012 wr_cmd_en  output  1  SHALL be a one-cycle write command request.
REQ-013 wr_cmd_addr  output  CTRL_ADDR_WIDTH  SHALL be the command start address.
REQ-014 wr_cmd_len  output  32  SHALL be the command length in beats.
REQ-015 wr_cmd_ready  input  1  SHALL indicate the write controller accepts a command.
REQ-016 wr_cmd_done  input  1  SHALL be a one-cycle pulse at command completion.
REQ-017 wr_data_re  input  1  SHALL be the beat read strobe from the write controller.
REQ-018 wr_ctrl_data  output  MEM_DQ_WIDTH*8  SHALL be the beat presented to the write controller.
REQ-019 fifo_level  output  log2(FIFO_DEPTH)+1  SHALL be the buffered beat count.
REQ-020 overflow, underflow  output  1 each  SHALL be sticky error flags.
REQ-021 frame_done  output  1  SHALL pulse one cycle when the last command of a frame completes.

Function
REQ-022 Packing SHALL place 8 pixels per beat, first pixel in bits [15:0], eighth in [127:112]; a 3-bit pack counter advances on pix_valid; on the 8th pixel the beat is pushed next cycle.
REQ-023 Buffer SHALL be first-word-fall-through; wr_ctrl_data equals the head beat combinationally; wr_data_re pops one beat per cycle.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-025 Push with fifo_level==FIFO_DEPTH and no pop SHALL drop the beat and set overflow.
REQ-026 wr_data_re with fifo_level==0 SHALL not change the pointers, SHALL hold wr_ctrl_data, and SHALL set underflow.
REQ-027 FSM states: IDLE, CMD, DATA, WAIT_DONE.
REQ-028 IDLE->CMD when fifo_level>=BURST_BEATS and wr_cmd_ready==1.
REQ-029 In CMD, wr_cmd_en SHALL be 1 for exactly one cycle with wr_cmd_addr=cur_addr and wr_cmd_len=BURST_BEATS, then go to DATA.
REQ-030 DATA SHALL count pops; after BURST_BEATS pops go to WAIT_DONE; wr_cmd_done seen in DATA after the final pop SHALL be taken as completion.
REQ-031 WAIT_DONE->IDLE on wr_cmd_done; cur_addr SHALL advance by BURST_BEATS*8 (address unit = one MEM_DQ_WIDTH word).
REQ-032 When FRAME_BEATS beats have completed, cur_addr SHALL return to BASE_ADDR, the beat counter SHALL clear, and frame_done SHALL pulse.
REQ-033 Address arithmetic SHALL be modulo 2^CTRL_ADDR_WIDTH.
REQ-034 frame_start SHALL clear the pack counter immediately, discarding a partial beat.
REQ-035 frame_start in IDLE SHALL flush the buffer and load cur_addr=BASE_ADDR.
REQ-036 frame_start in CMD, DATA or WAIT_DONE SHALL be latched and applied (flush plus address reload) on the WAIT_DONE->IDLE transition; the current command completes.
REQ-037 frame_start coincident with pix_valid SHALL make that pixel the first of the new frame.

Reset
REQ-038 While rst==1: wr_cmd_en=0, wr_cmd_addr=BASE_ADDR, wr_cmd_len=0, wr_ctrl_data=0, fifo_level=0, overflow=0, underflow=0, frame_done=0, FSM=IDLE, pack counter=0, cur_addr=BASE_ADDR, latched frame_start cleared.
REQ-039 Reset asserted mid-command SHALL abandon the command and discard all buffered data.

Verification
REQ-040 128 pixels with values 0..127, wr_cmd_ready=1 -> one wr_cmd_en, addr 0, len 16; first beat 0x0007_0006_..._0000.
REQ-041 Two full bursts, wr_cmd_done after each -> second command addr 128; third command addr 256.
REQ-042 FRAME_BEATS=32, 256 pixels -> frame_done pulses after the second wr_cmd_done; next command addr BASE_ADDR.
REQ-043 wr_cmd_ready=0 while 520 pixels are pushed -> fifo_level=64, overflow=1, no wr_cmd_en.
REQ-044 frame_start during DATA after 5 pops -> remaining 11 beats still served; next command addr BASE_ADDR with the buffer flushed.
REQ-045 wr_data_re with empty buffer -> underflow=1, fifo_level stays 0; rst pulse -> all outputs return to reset values.
